// File: rtl/control_unit_pkg.sv
// Shared encodings for the 16-bit CPU control path.
// Opcodes, ALU select/operation codes and the controller state enum.
package cpu_control_pkg;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0101;
   localparam logic [3:0] OP_ADDUI = 4'b0110;
   localparam logic [3:0] OP_SUBI  = 4'b1001;
   localparam logic [3:0] OP_CMPI  = 4'b1011;

   localparam logic [3:0] EXT_ADD  = 4'b0101;
   localparam logic [3:0] EXT_ADDU = 4'b0110;
   localparam logic [3:0] EXT_SUB  = 4'b1001;
   localparam logic [3:0] EXT_CMP  = 4'b1011;

   localparam logic [1:0] ALU_A_PC       = 2'b00;
   localparam logic [1:0] ALU_A_SOURCE   = 2'b01;
   localparam logic [1:0] ALU_A_IMM_SEXT = 2'b10;
   localparam logic [1:0] ALU_A_IMM_ZEXT = 2'b11;

   localparam logic ALU_B_DEST = 1'b0;
   localparam logic ALU_B_ONE  = 1'b1;

   localparam logic [1:0] ALU_ADD      = 2'b00;
   localparam logic [1:0] ALU_SUBTRACT = 2'b01;
   localparam logic [1:0] ALU_COMPARE  = 2'b10;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXECUTE,
      WRITEBACK,
      HALT
   } state_t;

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath bundle: latched instruction in,
// selects and write enables out.
interface control_unit_if;

   logic [15:0] instruction;
   logic [1:0]  alu_a_select;
   logic        alu_b_select;
   logic [1:0]  alu_operation;
   logic        program_counter_write_enable;
   logic        status_write_enable;
   logic        instruction_write_enable;
   logic        register_write_enable;

   modport master (
      input  instruction,
      output alu_a_select,
      output alu_b_select,
      output alu_operation,
      output program_counter_write_enable,
      output status_write_enable,
      output instruction_write_enable,
      output register_write_enable
   );

   modport slave (
      output instruction,
      input  alu_a_select,
      input  alu_b_select,
      input  alu_operation,
      input  program_counter_write_enable,
      input  status_write_enable,
      input  instruction_write_enable,
      input  register_write_enable
   );

endinterface

// File: rtl/control_unit_classifier.sv
// Combinational decode of the instruction word into the
// attributes the controller sequences on.
module instruction_classifier
   import cpu_control_pkg::*;
(
   input  logic [15:0] instruction,
   output logic        valid,
   output logic        is_immediate,
   output logic        is_zero_extended,
   output logic        is_compare,
   output logic [1:0]  alu_operation
);

   logic [3:0] opcode;
   logic [3:0] opext;
   logic       unused_fields;

   assign opcode        = instruction[15:12];
   assign opext         = instruction[7:4];
   assign unused_fields = ^{instruction[11:8], instruction[3:0]};

   always_comb begin
      valid            = 1'b0;
      is_immediate     = 1'b0;
      is_zero_extended = 1'b0;
      is_compare       = 1'b0;
      alu_operation    = ALU_ADD;
      unique case (opcode)
         OP_RTYPE: begin
            unique case (opext)
               EXT_ADD, EXT_ADDU: valid = 1'b1;
               EXT_SUB: begin
                  valid         = 1'b1;
                  alu_operation = ALU_SUBTRACT;
               end
               EXT_CMP: begin
                  valid         = 1'b1;
                  is_compare    = 1'b1;
                  alu_operation = ALU_COMPARE;
               end
               default: valid = 1'b0;
            endcase
         end
         OP_ADDI: begin
            valid        = 1'b1;
            is_immediate = 1'b1;
         end
         OP_ADDUI: begin
            valid            = 1'b1;
            is_immediate     = 1'b1;
            is_zero_extended = 1'b1;
         end
         OP_SUBI: begin
            valid         = 1'b1;
            is_immediate  = 1'b1;
            alu_operation = ALU_SUBTRACT;
         end
         OP_CMPI: begin
            valid         = 1'b1;
            is_immediate  = 1'b1;
            is_compare    = 1'b1;
            alu_operation = ALU_COMPARE;
         end
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle controller FSM with retired-instruction counter.
// Define CONTROL_UNIT_ILLEGAL_TRAP_EN to halt on illegal encodings.
module control_unit
   import cpu_control_pkg::*;
#(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   control_unit_if.master         bus,
   output logic [COUNT_WIDTH-1:0] retired_count
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
   ,
   output logic                   halted
`endif
);

   state_t     state;
   state_t     state_next;
   logic       retire;
   logic       valid;
   logic       is_immediate;
   logic       is_zero_extended;
   logic       is_compare;
   logic [1:0] class_operation;
   logic [1:0] execute_a;

   instruction_classifier classifier (
      .instruction      (bus.instruction),
      .valid            (valid),
      .is_immediate     (is_immediate),
      .is_zero_extended (is_zero_extended),
      .is_compare       (is_compare),
      .alu_operation    (class_operation)
   );

   assign execute_a = !is_immediate    ? ALU_A_SOURCE   :
                      is_zero_extended ? ALU_A_IMM_ZEXT :
                                         ALU_A_IMM_SEXT;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= FETCH;
         retired_count <= '0;
      end else begin
         state <= state_next;
         if (retire)
            retired_count <= retired_count + COUNT_WIDTH'(1);
      end
   end

   always_comb begin
      state_next                       = state;
      retire                           = 1'b0;
      bus.alu_a_select                 = ALU_A_PC;
      bus.alu_b_select                 = ALU_B_ONE;
      bus.alu_operation                = ALU_ADD;
      bus.program_counter_write_enable = 1'b0;
      bus.status_write_enable          = 1'b0;
      bus.instruction_write_enable     = 1'b0;
      bus.register_write_enable        = 1'b0;
      unique case (state)
         FETCH: begin
            bus.instruction_write_enable     = 1'b1;
            bus.program_counter_write_enable = 1'b1;
            state_next                       = DECODE;
         end
         DECODE: begin
            if (valid) begin
               state_next = EXECUTE;
            end else begin
               state_next = FETCH;
               retire     = 1'b1;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
               // all-zero word stays a NOP even when trapping
               if (bus.instruction != 16'h0000) begin
                  state_next = HALT;
                  retire     = 1'b0;
               end
`endif
            end
         end
         EXECUTE: begin
            bus.alu_a_select        = execute_a;
            bus.alu_b_select        = ALU_B_DEST;
            bus.alu_operation       = class_operation;
            bus.status_write_enable = 1'b1;
            if (is_compare) begin
               state_next = FETCH;
               retire     = 1'b1;
            end else begin
               state_next = WRITEBACK;
            end
         end
         WRITEBACK: begin
            bus.alu_a_select          = execute_a;
            bus.alu_b_select          = ALU_B_DEST;
            bus.alu_operation         = class_operation;
            bus.register_write_enable = 1'b1;
            state_next                = FETCH;
            retire                    = 1'b1;
         end
         HALT: state_next = HALT;
         default: state_next = FETCH;
      endcase
      if (!reset) begin
         bus.alu_a_select                 = ALU_A_PC;
         bus.alu_b_select                 = ALU_B_DEST;
         bus.alu_operation                = ALU_ADD;
         bus.program_counter_write_enable = 1'b0;
         bus.status_write_enable          = 1'b0;
         bus.instruction_write_enable     = 1'b0;
         bus.register_write_enable        = 1'b0;
      end
   end

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
   assign halted = reset && (state == HALT);
`endif

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed table, randomized model
// comparison, reset/wrap/halt sequences.
module tb_control_unit;

   localparam int CW = 12;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [CW-1:0] retired_count;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
   logic          halted;
`endif

   control_unit_if bus ();

   control_unit #(.COUNT_WIDTH(CW)) dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (bus),
      .retired_count (retired_count)
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
      ,
      .halted        (halted)
`endif
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int unsigned model_count = 0;

   typedef struct {
      logic [3:0] opc;
      bit         rtype;
      logic [3:0] ext;
      logic [1:0] a;
      logic [1:0] op;
      bit         cmp;
   } isa_t;

   isa_t isa [8];

   typedef struct {
      logic [15:0] instr;
      int          latency;
      logic [1:0]  a;
      logic [1:0]  op;
      bit          sw;
      bit          rw;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [8:0] outs();
      return {bus.alu_a_select, bus.alu_b_select, bus.alu_operation,
              bus.program_counter_write_enable, bus.status_write_enable,
              bus.instruction_write_enable, bus.register_write_enable};
   endfunction

   // Expected {a,b,op,pc,st,ir,rf} for each phase of an instruction
   function automatic logic [8:0] phase_out(int ph, logic [1:0] a, logic [1:0] op);
      case (ph)
         0: return {2'b00, 1'b1, 2'b00, 4'b1010};
         1: return {2'b00, 1'b1, 2'b00, 4'b0000};
         2: return {a, 1'b0, op, 4'b0100};
         default: return {a, 1'b0, op, 4'b0001};
      endcase
   endfunction

   function automatic bit lookup(logic [15:0] w, output isa_t e);
      e = isa[0];
      for (int i = 0; i < 8; i++)
         if (w[15:12] == isa[i].opc && (!isa[i].rtype || w[7:4] == isa[i].ext)) begin
            e = isa[i];
            return 1'b1;
         end
      return 1'b0;
   endfunction

   function automatic logic [CW-1:0] exp_count();
      return CW'(model_count);
   endfunction

   // Runs one instruction from FETCH, checking every cycle against the model
   task automatic run_model(logic [15:0] w);
      isa_t e;
      bit   found;
      int   n;
      found = lookup(w, e);
      n = !found ? 2 : (e.cmp ? 3 : 4);
      bus.instruction = w;
      for (int ph = 0; ph < n; ph++) begin
         chk($sformatf("rand_out_%0d", ph), 32'(outs()), 32'(phase_out(ph, e.a, e.op)));
         chk("rand_count", 32'(retired_count), 32'(exp_count()));
         tick();
      end
      model_count++;
   endtask

   task automatic run_vec(vec_t v);
      int         cyc;
      bit         sw;
      bit         rw;
      logic [1:0] a;
      logic [1:0] op;
      logic [1:0] wa;
      logic [1:0] wop;
      cyc = 0; sw = 0; rw = 0; a = 0; op = 0; wa = 0; wop = 0;
      bus.instruction = v.instr;
      do begin
         if (bus.status_write_enable) begin
            sw = 1; a = bus.alu_a_select; op = bus.alu_operation;
         end
         if (bus.register_write_enable) begin
            rw = 1; wa = bus.alu_a_select; wop = bus.alu_operation;
         end
         tick();
         cyc++;
      end while (!bus.instruction_write_enable && cyc < 8);
      model_count++;
      chk($sformatf("vec_%h_latency", v.instr), 32'(cyc), 32'(v.latency));
      chk($sformatf("vec_%h_status", v.instr), 32'(sw), 32'(v.sw));
      chk($sformatf("vec_%h_regwr", v.instr), 32'(rw), 32'(v.rw));
      chk($sformatf("vec_%h_exec_a", v.instr), 32'(a), 32'(v.a));
      chk($sformatf("vec_%h_exec_op", v.instr), 32'(op), 32'(v.op));
      if (v.rw) begin
         chk($sformatf("vec_%h_wb_a", v.instr), 32'(wa), 32'(v.a));
         chk($sformatf("vec_%h_wb_op", v.instr), 32'(wop), 32'(v.op));
      end
      chk($sformatf("vec_%h_count", v.instr), 32'(retired_count), 32'(exp_count()));
   endtask

   initial begin
      isa[0] = '{4'h0, 1, 4'h5, 2'b01, 2'b00, 0};
      isa[1] = '{4'h0, 1, 4'h6, 2'b01, 2'b00, 0};
      isa[2] = '{4'h0, 1, 4'h9, 2'b01, 2'b01, 0};
      isa[3] = '{4'h0, 1, 4'hB, 2'b01, 2'b10, 1};
      isa[4] = '{4'h5, 0, 4'h0, 2'b10, 2'b00, 0};
      isa[5] = '{4'h6, 0, 4'h0, 2'b11, 2'b00, 0};
      isa[6] = '{4'h9, 0, 4'h0, 2'b10, 2'b01, 0};
      isa[7] = '{4'hB, 0, 4'h0, 2'b10, 2'b10, 1};

      vecs.push_back('{16'h0355, 4, 2'b01, 2'b00, 1, 1});
      vecs.push_back('{16'hB2FF, 3, 2'b10, 2'b10, 1, 0});
      vecs.push_back('{16'h6480, 4, 2'b11, 2'b00, 1, 1});
      vecs.push_back('{16'h0000, 2, 2'b00, 2'b00, 0, 0});
      vecs.push_back('{16'h9A05, 4, 2'b10, 2'b01, 1, 1});
      vecs.push_back('{16'h0A90, 4, 2'b01, 2'b01, 1, 1});
      vecs.push_back('{16'h0FB0, 3, 2'b01, 2'b10, 1, 0});
      vecs.push_back('{16'h5123, 4, 2'b10, 2'b00, 1, 1});
      vecs.push_back('{16'h0363, 4, 2'b01, 2'b00, 1, 1});
`ifndef CONTROL_UNIT_ILLEGAL_TRAP_EN
      vecs.push_back('{16'hF123, 2, 2'b00, 2'b00, 0, 0});
      vecs.push_back('{16'h0007, 2, 2'b00, 2'b00, 0, 0});
`endif

      bus.instruction = 16'h0000;
      reset = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", 32'(outs()), 32'h0);
      chk("reset_count", 32'(retired_count), 32'h0);
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
      chk("reset_halted", 32'(halted), 32'h0);
`endif
      reset = 1'b1;
      #1;
      chk("first_fetch", 32'(outs()), 32'(phase_out(0, 2'b00, 2'b00)));

      foreach (vecs[i]) run_vec(vecs[i]);

      for (int i = 0; i < 300; i++) begin
         logic [15:0] w;
         isa_t        e;
         w = 16'($urandom);
         if ($urandom_range(1) == 0) begin
            e = isa[$urandom_range(7)];
            w[15:12] = e.opc;
            if (e.rtype) w[7:4] = e.ext;
         end
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
         if (!lookup(w, e)) w = 16'h0000;
`endif
         run_model(w);
      end

      // Reset during EXECUTE abandons the pending writeback
      bus.instruction = 16'h0355;
      tick();
      tick();
      chk("midreset_exec_status", 32'(bus.status_write_enable), 32'h1);
      reset = 1'b0;
      #1;
      chk("midreset_forced", 32'(outs()), 32'h0);
      tick();
      chk("midreset_no_regwr", 32'(bus.register_write_enable), 32'h0);
      reset = 1'b1;
      #1;
      model_count = 0;
      chk("midreset_fetch", 32'(outs()), 32'(phase_out(0, 2'b00, 2'b00)));
      chk("midreset_count", 32'(retired_count), 32'h0);

      bus.instruction = 16'h0000;
      repeat (2 * ((1 << CW) - 1)) tick();
      chk("wrap_allones", 32'(retired_count), 32'((1 << CW) - 1));
      repeat (2) tick();
      chk("wrap_zero", 32'(retired_count), 32'h0);
      model_count = 0;

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
      bus.instruction = 16'hF123;
      tick();
      tick();
      for (int i = 0; i < 100; i++) begin
         chk("halt_flag", 32'(halted), 32'h1);
         chk("halt_enables", 32'(outs() & 9'h00F), 32'h0);
         chk("halt_count", 32'(retired_count), 32'h0);
         tick();
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("halt_cleared", 32'(halted), 32'h0);
      chk("halt_refetch", 32'(outs()), 32'(phase_out(0, 2'b00, 2'b00)));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
